// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - coin decode, handshake and credit accumulator for the vending machine
//
// Purpose:
//   Decodes a coin code into a value through a small parameter table and handshakes with the
//   coin mechanism, counting one coin per coin_valid assertion. It accumulates credit with
//   an overflow check and serves spend and refund (clear) requests from the vend controller.
//
// Optional feature macro: COIN_ACCEPTOR_STATS_EN
//   When defined, this adds accept_cnt/reject_cnt, which are 16-bit wrapping event counters.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   coin_valid, coin_code         coin present (level) and its code
//   coin_ready                    high in IDLE: a new coin may be sampled
//   coin_value                    value of the last accepted coin
//   coin_accept, coin_reject      1-cycle result pulses
//   credit                        current credit
//   spend_valid, spend_amt        spend strobe and amount
//   spend_ok, spend_fail          1-cycle spend result pulses
//   clear                         refund strobe
//   refund_valid, refund_amt      1-cycle refund pulse, refunded amount (held)
//   accept_cnt, reject_cnt        (COIN_ACCEPTOR_STATS_EN only) event counters

module coin_acceptor #(
    parameter int CODE_W     = 2,
    parameter int VAL_W      = 5,
    parameter int CREDIT_W   = 8,
    parameter int CREDIT_MAX = 255,
    parameter int VAL0       = 1,
    parameter int VAL1       = 5,
    parameter int VAL2       = 10,
    parameter int VAL3       = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [CODE_W-1:0]   coin_code,
    output logic                coin_ready,
    output logic [VAL_W-1:0]    coin_value,
    output logic                coin_accept,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    input  logic                spend_valid,
    input  logic [CREDIT_W-1:0] spend_amt,
    output logic                spend_ok,
    output logic                spend_fail,
    input  logic                clear,
    output logic                refund_valid,
`ifdef COIN_ACCEPTOR_STATS_EN
    output logic [15:0]         accept_cnt,
    output logic [15:0]         reject_cnt,
`endif
    output logic [CREDIT_W-1:0] refund_amt
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_REL = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                r_coin_accept;
    logic                r_coin_reject;
    logic [VAL_W-1:0]    r_coin_value;
    logic [CREDIT_W-1:0] r_credit;
    logic                r_spend_ok;
    logic                r_spend_fail;
    logic                r_refund_valid;
    logic [CREDIT_W-1:0] r_refund_amt;

    logic                w_sample;
    logic                w_in_table;
    logic [VAL_W-1:0]    w_val;
    logic                w_spend_ok;
    logic                w_spend_fail;
    logic [CREDIT_W-1:0] w_base;
    logic [CREDIT_W:0]   w_sum;
    logic                w_coin_good;
    logic [CREDIT_W-1:0] w_credit_next;

    // Handshake FSM: one coin per coin_valid assertion; WAIT_REL blocks re-sampling of a
    // held coin until the mechanism drops coin_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sample     = 1'b0;
        case (r_state)
            IDLE: begin
                if (coin_valid) begin
                    w_sample     = 1'b1;
                    w_state_next = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!coin_valid) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Only codes 0..3 live in the table; wider code buses treat everything above as invalid.
    generate
        if (CODE_W > 2) begin : g_wide_code
            assign w_in_table = ~|coin_code[CODE_W-1:2];
        end else begin : g_narrow_code
            assign w_in_table = 1'b1;
        end
    endgenerate

    always_comb begin
        w_val = '0;
        case (coin_code[1:0])
            2'd0:    w_val = VAL_W'(VAL0);
            2'd1:    w_val = VAL_W'(VAL1);
            2'd2:    w_val = VAL_W'(VAL2);
            default: w_val = VAL_W'(VAL3);
        endcase
        if (!w_in_table) begin
            w_val = '0;
        end
    end

    // Spend is judged on the credit at the start of the cycle; clear blocks it outright.
    // Clear zeroes the base so a coin arriving with it becomes the entire new credit.
    always_comb begin
        w_spend_ok    = spend_valid && !clear && (spend_amt <= r_credit);
        w_spend_fail  = spend_valid && (clear || (spend_amt > r_credit));
        w_base        = clear ? '0 : (w_spend_ok ? (r_credit - spend_amt) : r_credit);
        w_sum         = {1'b0, w_base} + {{(CREDIT_W + 1 - VAL_W){1'b0}}, w_val};
        w_coin_good   = w_sample && (w_val != '0) && (w_sum <= (CREDIT_W + 1)'(CREDIT_MAX));
        w_credit_next = w_coin_good ? w_sum[CREDIT_W-1:0] : w_base;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coin_accept  <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_coin_value   <= '0;
            r_credit       <= '0;
            r_spend_ok     <= 1'b0;
            r_spend_fail   <= 1'b0;
            r_refund_valid <= 1'b0;
            r_refund_amt   <= '0;
        end else begin
            r_coin_accept  <= w_coin_good;
            r_coin_reject  <= w_sample && !w_coin_good;
            r_credit       <= w_credit_next;
            r_spend_ok     <= w_spend_ok;
            r_spend_fail   <= w_spend_fail;
            r_refund_valid <= clear;
            if (w_coin_good) begin
                r_coin_value <= w_val;
            end
            if (clear) begin
                r_refund_amt <= r_credit;
            end
        end
    end

`ifdef COIN_ACCEPTOR_STATS_EN
    logic [15:0] r_accept_cnt;
    logic [15:0] r_reject_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_accept_cnt <= '0;
            r_reject_cnt <= '0;
        end else begin
            if (w_coin_good) begin
                r_accept_cnt <= r_accept_cnt + 16'd1;
            end
            if (w_sample && !w_coin_good) begin
                r_reject_cnt <= r_reject_cnt + 16'd1;
            end
        end
    end

    assign accept_cnt = r_accept_cnt;
    assign reject_cnt = r_reject_cnt;
`endif

    assign coin_ready   = (r_state == IDLE);
    assign coin_value   = r_coin_value;
    assign coin_accept  = r_coin_accept;
    assign coin_reject  = r_coin_reject;
    assign credit       = r_credit;
    assign spend_ok     = r_spend_ok;
    assign spend_fail   = r_spend_fail;
    assign refund_valid = r_refund_valid;
    assign refund_amt   = r_refund_amt;

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - directed self-checking bench for coin_acceptor

module tb_coin_acceptor;

    logic       clk;
    logic       rst_n;
    logic       coin_valid;
    logic [1:0] coin_code;
    logic       coin_ready;
    logic [4:0] coin_value;
    logic       coin_accept;
    logic       coin_reject;
    logic [7:0] credit;
    logic       spend_valid;
    logic [7:0] spend_amt;
    logic       spend_ok;
    logic       spend_fail;
    logic       clear;
    logic       refund_valid;
    logic [7:0] refund_amt;
`ifdef COIN_ACCEPTOR_STATS_EN
    logic [15:0] accept_cnt;
    logic [15:0] reject_cnt;
`endif

    int checks = 0;
    int errors = 0;

    coin_acceptor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin_valid   (coin_valid),
        .coin_code    (coin_code),
        .coin_ready   (coin_ready),
        .coin_value   (coin_value),
        .coin_accept  (coin_accept),
        .coin_reject  (coin_reject),
        .credit       (credit),
        .spend_valid  (spend_valid),
        .spend_amt    (spend_amt),
        .spend_ok     (spend_ok),
        .spend_fail   (spend_fail),
        .clear        (clear),
        .refund_valid (refund_valid),
`ifdef COIN_ACCEPTOR_STATS_EN
        .accept_cnt   (accept_cnt),
        .reject_cnt   (reject_cnt),
`endif
        .refund_amt   (refund_amt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a coin for 'hold' cycles, check the single result pulse, then release.
    task automatic insert_coin(input logic [1:0] code, input int hold, input logic exp_acc,
                               input int exp_credit, input int exp_value);
        coin_valid = 1'b1;
        coin_code  = code;
        tick();
        chk("coin_accept", 32'(coin_accept), 32'(exp_acc));
        chk("coin_reject", 32'(coin_reject), 32'(!exp_acc));
        chk("credit", 32'(credit), 32'(exp_credit));
        chk("coin_value", 32'(coin_value), 32'(exp_value));
        chk("ready_low", 32'(coin_ready), 32'd0);
        for (int i = 1; i < hold; i++) begin
            tick();
            chk("held_no_pulse", 32'(coin_accept | coin_reject), 32'd0);
            chk("held_ready_low", 32'(coin_ready), 32'd0);
            chk("held_credit", 32'(credit), 32'(exp_credit));
        end
        coin_valid = 1'b0;
        tick();
        chk("ready_back", 32'(coin_ready), 32'd1);
    endtask

    task automatic do_spend(input int amt, input logic exp_ok, input int exp_credit);
        spend_valid = 1'b1;
        spend_amt   = 8'(amt);
        tick();
        spend_valid = 1'b0;
        chk("spend_ok", 32'(spend_ok), 32'(exp_ok));
        chk("spend_fail", 32'(spend_fail), 32'(!exp_ok));
        chk("spend_credit", 32'(credit), 32'(exp_credit));
        tick();
        chk("spend_pulse_end", 32'(spend_ok | spend_fail), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        coin_valid  = 1'b0;
        coin_code   = 2'd0;
        spend_valid = 1'b0;
        spend_amt   = 8'd0;
        clear       = 1'b0;
        #12;
        chk("rst_credit", 32'(credit), 32'd0);
        chk("rst_ready", 32'(coin_ready), 32'd1);
        chk("rst_value", 32'(coin_value), 32'd0);
        chk("rst_refund_amt", 32'(refund_amt), 32'd0);
        chk("rst_pulses", 32'({coin_accept, coin_reject, spend_ok, spend_fail, refund_valid}), 32'd0);
        rst_n = 1'b1;

        // 1: pennies, nickels, dimes held three cycles each
        insert_coin(2'd0, 3, 1'b1, 1, 1);
        insert_coin(2'd1, 3, 1'b1, 6, 5);
        insert_coin(2'd2, 3, 1'b1, 16, 10);

        // 2: code 3 has value 0 and is invalid
        insert_coin(2'd3, 2, 1'b0, 16, 10);

        // 3: fill to 250, then check overflow rejection and exact-max acceptance
        for (int i = 1; i <= 23; i++) insert_coin(2'd2, 1, 1'b1, 16 + 10 * i, 10);
        for (int i = 1; i <= 4; i++) insert_coin(2'd0, 1, 1'b1, 246 + i, 1);
        insert_coin(2'd2, 1, 1'b0, 250, 1);
        insert_coin(2'd1, 1, 1'b1, 255, 5);

        // 4: spends
        do_spend(239, 1'b1, 16);
        do_spend(20, 1'b0, 16);
        do_spend(0, 1'b1, 16);
        spend_valid = 1'b1;
        spend_amt   = 8'd16;
        coin_valid  = 1'b1;
        coin_code   = 2'd1;
        tick();
        spend_valid = 1'b0;
        chk("combo_spend_ok", 32'(spend_ok), 32'd1);
        chk("combo_accept", 32'(coin_accept), 32'd1);
        chk("combo_credit", 32'(credit), 32'd5);
        coin_valid = 1'b0;
        tick();
        chk("combo_ready", 32'(coin_ready), 32'd1);

        // 5: clear with spend and coin in the same cycle
        insert_coin(2'd1, 1, 1'b1, 10, 5);
        insert_coin(2'd0, 1, 1'b1, 11, 1);
        insert_coin(2'd0, 1, 1'b1, 12, 1);
        clear       = 1'b1;
        spend_valid = 1'b1;
        spend_amt   = 8'd3;
        coin_valid  = 1'b1;
        coin_code   = 2'd0;
        tick();
        clear       = 1'b0;
        spend_valid = 1'b0;
        chk("clr_refund_amt", 32'(refund_amt), 32'd12);
        chk("clr_refund_valid", 32'(refund_valid), 32'd1);
        chk("clr_spend_fail", 32'(spend_fail), 32'd1);
        chk("clr_spend_ok", 32'(spend_ok), 32'd0);
        chk("clr_accept", 32'(coin_accept), 32'd1);
        chk("clr_credit", 32'(credit), 32'd1);
        coin_valid = 1'b0;
        tick();
        chk("clr_refund_end", 32'(refund_valid), 32'd0);
        chk("clr_refund_hold", 32'(refund_amt), 32'd12);

        // 6: async reset in the middle of WAIT_REL
        insert_coin(2'd2, 1, 1'b1, 11, 10);
        insert_coin(2'd1, 1, 1'b1, 16, 5);
        coin_valid = 1'b1;
        coin_code  = 2'd3;
        tick();
        chk("pre_rst_reject", 32'(coin_reject), 32'd1);
        chk("pre_rst_credit", 32'(credit), 32'd16);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_credit", 32'(credit), 32'd0);
        chk("async_ready", 32'(coin_ready), 32'd1);
        chk("async_value", 32'(coin_value), 32'd0);
`ifdef COIN_ACCEPTOR_STATS_EN
        chk("async_accept_cnt", 32'(accept_cnt), 32'd0);
        chk("async_reject_cnt", 32'(reject_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        chk("resample_reject", 32'(coin_reject), 32'd1);
        chk("resample_ready", 32'(coin_ready), 32'd0);
        chk("resample_credit", 32'(credit), 32'd0);
`ifdef COIN_ACCEPTOR_STATS_EN
        chk("resample_reject_cnt", 32'(reject_cnt), 32'd1);
`endif
        coin_valid = 1'b0;
        tick();
        insert_coin(2'd0, 1, 1'b1, 1, 1);
`ifdef COIN_ACCEPTOR_STATS_EN
        chk("final_accept_cnt", 32'(accept_cnt), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
